// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the five-stage RV32I pipeline.
// It generates the operand forwarding selects, the stall enables and the
// flush controls for the Fetch/Decode/Execute/Memory/Writeback registers.
// It resolves load-use and taken-branch hazards. It freezes the whole pipe
// while a handshaked data-memory access is outstanding. A watchdog abandons
// an access after TIMEOUT wait cycles. A saturating counter records how many
// cycles Fetch was stalled.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Rs1D, Rs2D               source registers in Decode
//   Rs1E, Rs2E, RdE          source / destination registers in Execute
//   RdM, RdW                 destination registers in Memory / Writeback
//   RegWriteM, RegWriteW     register-write enables in Memory / Writeback
//   ResultSrcE               result select in Execute (2'b01 = load)
//   PCSrcE                   taken branch / jump resolved in Execute
//   MemReqM, MemReadyM       data-memory request / completion handshake
//   ForwardAE, ForwardBE     operand select (00 regfile, 01 WB, 10 MEM)
//   StallF/D/E/M             hold PC / pipeline registers
//   FlushD/E/W               clear Decode / Execute / Writeback to a bubble
//   MemTimeout               sticky: an access was abandoned
//   StallCount               saturating count of cycles with StallF high
module pipeline_hazard_ctrl #(
    parameter int A_WIDTH   = 5,
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [A_WIDTH-1:0]   Rs1D,
    input  logic [A_WIDTH-1:0]   Rs2D,
    input  logic [A_WIDTH-1:0]   Rs1E,
    input  logic [A_WIDTH-1:0]   Rs2E,
    input  logic [A_WIDTH-1:0]   RdE,
    input  logic [A_WIDTH-1:0]   RdM,
    input  logic [A_WIDTH-1:0]   RdW,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic [1:0]           ResultSrcE,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic                 MemTimeout,
    output logic [CNT_WIDTH-1:0] StallCount
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0]      WC_MAX  = WC_W'(TIMEOUT);
    localparam logic [WC_W-1:0]      WC_ONE  = WC_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [A_WIDTH-1:0]   REG_X0  = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [WC_W-1:0]       wcnt_q, wcnt_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  memStall;
    logic                  loadStall;

    // State, watchdog, sticky timeout flag and the saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
            if (StallF && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    // Next state. WCnt equals the number of cycles the current access has
    // already been stalled, so reaching TIMEOUT means the budget is spent.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WC_ONE;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WC_MAX) begin
                    state_d   = RUN;
                    wcnt_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WC_ONE;
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // Outputs. A memory stall freezes everything and masks branch and
    // load-use handling, which then take effect on the release cycle. A
    // taken branch flushes the dependent instruction, so it wins over
    // load-use.
    always_comb begin
        if (state_q == RUN) begin
            memStall = MemReqM && !MemReadyM;
        end else begin
            memStall = !MemReadyM && (wcnt_q != WC_MAX);
        end
        loadStall = (ResultSrcE == 2'b01) && (RdE != REG_X0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

        ForwardAE = 2'b00;
        if (RegWriteM && (RdM != REG_X0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != REG_X0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != REG_X0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != REG_X0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end

        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (memStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (loadStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end

        // During reset every stage is held as a bubble with no forwarding.
        if (rst) begin
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
        end
    end

    assign MemTimeout = timeout_q;
    assign StallCount = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int AW   = 5;
    localparam int TOUT = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    // Control vector order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_MEM   = 7'b1111001;
    localparam logic [6:0] C_BR    = 7'b0000110;
    localparam logic [6:0] C_LOAD  = 7'b1100010;
    localparam logic [6:0] C_RESET = 7'b0000111;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, MemReqM, MemReadyM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM;
    logic          FlushD, FlushE, FlushW;
    logic          MemTimeout;
    logic [CW-1:0] StallCount;

    int checks = 0;
    int errors = 0;

    // Reference model state: stall cycles already spent on the outstanding
    // memory access (0 = none outstanding), sticky timeout, stall count.
    int mWaited  = 0;
    bit mTimeout = 1'b0;
    int mCount   = 0;

    typedef struct {
        logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic          rwm, rww;
        logic [1:0]    rse;
        logic          pcs;
        logic [1:0]    expA, expB;
        logic [6:0]    expCtrl;
    } vec_t;

    vec_t vecs[12];

    pipeline_hazard_ctrl #(
        .A_WIDTH   (AW),
        .TIMEOUT   (TOUT),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .MemTimeout (MemTimeout),
        .StallCount (StallCount)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] expFwd(input logic [AW-1:0] rs);
        if (rst) return 2'b00;
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit modelMemStall();
        if (mWaited == 0) return MemReqM && !MemReadyM;
        return !MemReadyM && (mWaited < TOUT);
    endfunction

    function automatic logic [6:0] expCtrl();
        bit load;
        load = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (rst) return C_RESET;
        if (modelMemStall()) return C_MEM;
        if (PCSrcE) return C_BR;
        if (load) return C_LOAD;
        return C_NONE;
    endfunction

    always @(posedge clk) begin
        logic [6:0] c;
        c = expCtrl();
        if (rst) begin
            mWaited  <= 0;
            mTimeout <= 1'b0;
            mCount   <= 0;
        end else begin
            if (c[6] && mCount < CMAX) mCount <= mCount + 1;
            if (modelMemStall()) begin
                mWaited <= mWaited + 1;
            end else begin
                if (mWaited == TOUT && !MemReadyM) mTimeout <= 1'b1;
                mWaited <= 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearInputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
        RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
        RegWriteM = v.rwm; RegWriteW = v.rww; ResultSrcE = v.rse;
        PCSrcE = v.pcs; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [6:0] ctrlNow();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    function automatic vec_t mk(input logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                                input logic rwm, rww, input logic [1:0] rse,
                                input logic pcs, input logic [1:0] a, b,
                                input logic [6:0] c);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
        v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww; v.rse = rse; v.pcs = pcs;
        v.expA = a; v.expB = b; v.expCtrl = c;
        return v;
    endfunction

    initial begin
        //             rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rse    pcs  A      B      ctrl
        vecs[0]  = mk(0, 0, 5, 0, 0, 5, 5, 1, 1, 2'b00, 0, 2'b10, 2'b00, C_NONE);
        vecs[1]  = mk(0, 0, 5, 0, 0, 5, 5, 0, 1, 2'b00, 0, 2'b01, 2'b00, C_NONE);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 5, 1, 1, 2'b00, 0, 2'b00, 2'b00, C_NONE);
        vecs[3]  = mk(0, 0, 3, 3, 0, 3, 3, 1, 1, 2'b00, 0, 2'b10, 2'b10, C_NONE);
        vecs[4]  = mk(0, 0, 1, 9, 0, 9, 9, 0, 1, 2'b00, 0, 2'b00, 2'b01, C_NONE);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00, C_NONE);
        vecs[6]  = mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, C_LOAD);
        vecs[7]  = mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, C_LOAD);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, C_NONE);
        vecs[9]  = mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, C_NONE);
        vecs[10] = mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, C_BR);
        vecs[11] = mk(0, 0, 4, 2, 0, 2, 4, 1, 1, 2'b00, 1, 2'b01, 2'b10, C_BR);

        clearInputs();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("reset_ctrl", 32'(ctrlNow()), 32'(C_RESET));
        checkOutput("reset_fwdA", 32'(ForwardAE), 32'd0);
        checkOutput("reset_timeout", 32'(MemTimeout), 32'd0);
        checkOutput("reset_count", 32'(StallCount), 32'd0);
        rst = 1'b0;
        tick();

        // Combinational vectors in RUN state.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_fwdA", i), 32'(ForwardAE), 32'(vecs[i].expA));
            checkOutput($sformatf("vec%0d_fwdB", i), 32'(ForwardBE), 32'(vecs[i].expB));
            checkOutput($sformatf("vec%0d_ctrl", i), 32'(ctrlNow()), 32'(vecs[i].expCtrl));
            tick();
        end

        // Single load-use stall: count moves 0 -> 1.
        clearInputs();
        doReset();
        applyStimulus(vecs[6]);
        @(negedge clk);
        checkOutput("loaduse_ctrl", 32'(ctrlNow()), 32'(C_LOAD));
        tick();
        clearInputs();
        @(negedge clk);
        checkOutput("loaduse_count", 32'(StallCount), 32'd1);
        checkOutput("loaduse_after", 32'(ctrlNow()), 32'(C_NONE));
        tick();

        // Memory ready on wait cycle 3 with a branch held throughout.
        doReset();
        MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("memwait%0d_ctrl", i), 32'(ctrlNow()), 32'(C_MEM));
            tick();
        end
        MemReadyM = 1'b1;
        @(negedge clk);
        checkOutput("memwait_release", 32'(ctrlNow()), 32'(C_BR));
        tick();
        PCSrcE = 1'b0;
        @(negedge clk);
        checkOutput("memwait_count", 32'(StallCount), 32'd3);
        checkOutput("memwait_run_hit", 32'(ctrlNow()), 32'(C_NONE));
        checkOutput("memwait_notimeout", 32'(MemTimeout), 32'd0);
        tick();

        // Watchdog: ready never comes.
        clearInputs();
        doReset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < TOUT; i++) begin
            @(negedge clk);
            checkOutput($sformatf("tout%0d_ctrl", i), 32'(ctrlNow()), 32'(C_MEM));
            tick();
        end
        @(negedge clk);
        checkOutput("tout_release", 32'(ctrlNow()), 32'(C_NONE));
        checkOutput("tout_flag_pre", 32'(MemTimeout), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("tout_rewait", 32'(ctrlNow()), 32'(C_MEM));
        checkOutput("tout_flag", 32'(MemTimeout), 32'd1);
        checkOutput("tout_count", 32'(StallCount), 32'(TOUT));
        tick();
        @(negedge clk);
        checkOutput("tout_sticky", 32'(MemTimeout), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("tout_rst_ctrl", 32'(ctrlNow()), 32'(C_RESET));
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("tout_rst_flag", 32'(MemTimeout), 32'd0);
        checkOutput("tout_rst_count", 32'(StallCount), 32'd0);
        checkOutput("tout_rst_run", 32'(ctrlNow()), 32'(C_MEM));
        tick();

        // Counter saturation: 20 load-use stall cycles.
        clearInputs();
        doReset();
        applyStimulus(vecs[6]);
        for (int i = 0; i < 20; i++) tick();
        clearInputs();
        @(negedge clk);
        checkOutput("sat_count", 32'(StallCount), 32'(CMAX));
        tick();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            Rs1D       = AW'($urandom_range(0, 3));
            Rs2D       = AW'($urandom_range(0, 3));
            Rs1E       = AW'($urandom_range(0, 3));
            Rs2E       = AW'($urandom_range(0, 3));
            RdE        = AW'($urandom_range(0, 3));
            RdM        = AW'($urandom_range(0, 3));
            RdW        = AW'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom);
            RegWriteW  = 1'($urandom);
            ResultSrcE = 2'($urandom);
            PCSrcE     = ($urandom_range(0, 4) == 0);
            MemReqM    = 1'($urandom);
            MemReadyM  = ($urandom_range(0, 9) < 3);
            @(negedge clk);
            checkOutput("rnd_fwdA", 32'(ForwardAE), 32'(expFwd(Rs1E)));
            checkOutput("rnd_fwdB", 32'(ForwardBE), 32'(expFwd(Rs2E)));
            checkOutput("rnd_ctrl", 32'(ctrlNow()), 32'(expCtrl()));
            checkOutput("rnd_timeout", 32'(MemTimeout), 32'(mTimeout));
            checkOutput("rnd_count", 32'(StallCount), 32'(mCount));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
